// File: rtl/cordic_multiplier_exact_if.sv
// Operand/result bundle for cordic_multiplier_exact.
//   start : operation request (sampled only while the multiplier is idle/done)
//   x, z  : signed WIDTH-bit operands
//   y     : signed 2*WIDTH-bit product, valid while done=1
//   done  : result-valid level, held until the next accepted start
// master drives the operands (requester); slave is the multiplier.
interface cordic_multiplier_exact_if #(
  parameter int WIDTH = 8
);
  logic                        start;
  logic signed [WIDTH-1:0]     x;
  logic signed [WIDTH-1:0]     z;
  logic signed [2*WIDTH-1:0]   y;
  logic                        done;

  modport master (output start, x, z, input y, done);
  modport slave  (input start, x, z, output y, done);
endinterface

// File: rtl/cordic_multiplier_exact.sv
// Sequential signed WIDTH x WIDTH multiplier built on linear-mode CORDIC.
// The sign of the residual angle zr picks a +/-1 direction each step, the
// shifted multiplicand is added or subtracted into acc, and a final step
// folds the leftover residual (always -1, 0 or +1) back in so y == x*z
// exactly. Latency: done rises WIDTH+1 edges after the accepting edge.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, aborts any operation in flight
//   bus : slave side of cordic_multiplier_exact_if (start/x/z in, y/done out)
module cordic_multiplier_exact #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  cordic_multiplier_exact_if.slave     bus
);

  localparam int AW = 2*WIDTH + 2;  // accumulator: covers |x|*(2^WIDTH-1)
  localparam int ZW = WIDTH + 2;    // residual angle: covers +/-(2^WIDTH-1)
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

  state_t               state, next_state;
  logic signed [AW-1:0] xr, acc, step_x, acc_corr;
  logic signed [ZW-1:0] zr, step_z;
  logic [IW-1:0]        i;
  logic signed [2*WIDTH-1:0] y_q;
  logic                 done_q;
  logic                 accept;

  assign bus.y    = y_q;
  assign bus.done = done_q;

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign step_x = xr <<< i;
  assign step_z = {{(ZW-1){1'b0}}, 1'b1} << i;

  // Residual is in {-1,0,+1} here, so the correction is a single add/sub of xr.
  always_comb begin
    acc_corr = acc;
    if (zr[ZW-1])
      acc_corr = acc - xr;
    else if (zr != '0)
      acc_corr = acc + xr;
  end

  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (bus.start) next_state = ITER;
      ITER:       if (i == '0)   next_state = CORR;
      CORR:                      next_state = DONE;
      default:                   next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr     <= '0;
      zr     <= '0;
      acc    <= '0;
      i      <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            xr     <= {{(AW-WIDTH){bus.x[WIDTH-1]}}, bus.x};
            zr     <= {{(ZW-WIDTH){bus.z[WIDTH-1]}}, bus.z};
            acc    <= '0;
            i      <= IW'(WIDTH-1);
            done_q <= 1'b0;
          end
        end
        ITER: begin
          // Non-restoring: a non-negative residual means rotate by +2^i.
          if (!zr[ZW-1]) begin
            acc <= acc + step_x;
            zr  <= zr - step_z;
          end else begin
            acc <= acc - step_x;
            zr  <= zr + step_z;
          end
          i <= i - 1'b1;
        end
        CORR: begin
          acc    <= acc_corr;
          y_q    <= acc_corr[2*WIDTH-1:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_multiplier_exact.sv
module tb_cordic_multiplier_exact;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cordic_multiplier_exact_if #(.WIDTH(WIDTH)) bus ();

  cordic_multiplier_exact #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present operands at the falling edge and hold start across one rising edge.
  task automatic launch(input int a, input int b);
    @(negedge clk);
    bus.x     = 8'(a);
    bus.z     = 8'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count rising edges until done is seen; bounded so a dead DUT cannot hang.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Reference: the product of the operands as plain integers.
  task automatic do_op(input string tag, input int a, input int b);
    int n;
    launch(a, b);
    check({tag, "_clr"}, int'(bus.done), 0);
    wait_done(n);
    check({tag, "_lat"}, n, 9);
    check({tag, "_y"}, int'($signed(bus.y)), a * b);
  endtask

  initial begin
    int n, a, b;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.z     = '0;

    #12;
    check("rst_y", int'($signed(bus.y)), 0);
    check("rst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Corners and residual-correction cases (even z leaves a nonzero residual).
    do_op("c_max",   127,  127);
    do_op("c_minmin",-128, -128);
    do_op("c_minmax",-128,  127);
    do_op("c_zero",    0,  -77);
    do_op("c_small",   5,   -3);
    do_op("r_z0",     -1,    0);
    do_op("r_zmin",   -1, -128);
    do_op("r_z64",    -1,   64);

    // Result holds while start stays low.
    repeat (5) @(posedge clk);
    #1;
    check("hold_y", int'($signed(bus.y)), -64);
    check("hold_done", int'(bus.done), 1);

    // A start during ITER is ignored; the in-flight result completes.
    launch(3, 4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.x = 8'd7; bus.z = 8'd7; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x = 8'd99; bus.z = 8'd99;   // operand changes after acceptance are harmless
    wait_done(n);
    check("busy_lat", n, 6);
    check("busy_y", int'($signed(bus.y)), 12);
    do_op("after_busy", 7, 7);

    // Start held high: back-to-back operations, done high one cycle each.
    @(negedge clk);
    bus.x = 8'd2; bus.z = 8'd3; bus.start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n);
    check("b2b_y1", int'($signed(bus.y)), 6);
    @(negedge clk);
    bus.x = -8'sd6; bus.z = 8'd11;
    @(posedge clk);
    #1;
    check("b2b_clr", int'(bus.done), 0);
    bus.start = 1'b0;
    wait_done(n);
    check("b2b_lat", n, 9);
    check("b2b_y2", int'($signed(bus.y)), -66);

    // Asynchronous reset mid-operation clears y and done before any edge.
    launch(10, 10);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("amid_y", int'($signed(bus.y)), 0);
    check("amid_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("amid_idle", int'(bus.done), 0);
    do_op("post_rst", -9, 11);

    // Randomized operands against the integer product.
    for (int k = 0; k < 400; k++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      do_op("rand", a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
